// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited sharing of one FIFO write port.
// Define FIFO_ARB_STATS_EN to add the wr_count / stall_count statistics outputs.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data_in,
  output logic [N_REQ-1:0]         grant,
  output logic                     write,
  output logic [WIDTH-1:0]         dato_entrada,
  input  logic [$clog2(DEPTH)-1:0] use_dw,
  input  logic                     lleno,
  output logic [$clog2(N_REQ)-1:0] owner
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]              wr_count,
  output logic [15:0]              stall_count
`endif
);

  localparam int OW = $clog2(N_REQ);
  localparam int UW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_reg, state_next;
  logic [OW-1:0]    owner_reg, owner_next;
  logic [BW-1:0]    burst_cnt_reg, burst_cnt_next;
  logic             write_reg;
  logic [WIDTH-1:0] dato_reg;

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic [UW+1:0]    occ_sum;
  logic             space;
  logic             any_req;
  logic             keep_owner;
  logic             grant_en;
  logic [OW-1:0]    grant_idx;
  logic [OW-1:0]    rr_idx;
  logic [OW-1:0]    rr_win;
  logic             rr_found;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign data_arr[gi] = data_in[gi*WIDTH +: WIDTH];
      assign grant[gi]    = grant_en && (grant_idx == OW'(gi));
    end
  endgenerate

  // Occupancy includes the word still sitting in the write register.
  assign occ_sum    = {1'b0, lleno, use_dw} + {{(UW+1){1'b0}}, write_reg};
  assign space      = (occ_sum < (UW+2)'(DEPTH));
  assign any_req    = |req;
  assign keep_owner = (state_reg == BURST) && req[owner_reg] &&
                      (burst_cnt_reg < BW'(MAX_BURST));

  // Search owner+1 .. owner+N_REQ so the current owner is visited last.
  always_comb begin
    rr_idx   = owner_reg;
    rr_win   = owner_reg;
    rr_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = (rr_idx == OW'(N_REQ - 1)) ? '0 : rr_idx + 1'b1;
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    grant_en       = 1'b0;
    grant_idx      = owner_reg;
    if (space) begin
      if (!any_req) begin
        state_next     = IDLE;
        burst_cnt_next = '0;
      end else if (keep_owner) begin
        grant_en       = 1'b1;
        burst_cnt_next = burst_cnt_reg + BW'(1);
      end else begin
        grant_en       = 1'b1;
        grant_idx      = rr_win;
        owner_next     = rr_win;
        burst_cnt_next = BW'(1);
        state_next     = BURST;
      end
    end
    if (!reset) begin
      grant_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
      write_reg     <= 1'b0;
      dato_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      write_reg     <= grant_en;
      if (grant_en) begin
        dato_reg <= data_arr[grant_idx];
      end
    end
  end

  assign write        = write_reg;
  assign dato_entrada = dato_reg;
  assign owner        = owner_reg;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] wr_count_reg;
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_reg    <= '0;
      stall_count_reg <= '0;
    end else begin
      if (write_reg && (wr_count_reg != 16'hFFFF)) begin
        wr_count_reg <= wr_count_reg + 16'd1;
      end
      if (any_req && !space && (stall_count_reg != 16'hFFFF)) begin
        stall_count_reg <= stall_count_reg + 16'd1;
      end
    end
  end

  assign wr_count    = wr_count_reg;
  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed plus randomized checks of fifo_wr_arbiter against
// a rule-level arbitration model and a queue-based FIFO owned by the bench.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 32;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   grant;
  logic           write;
  logic [W-1:0]   dato_entrada;
  logic [4:0]     use_dw = '0;
  logic           lleno = 1'b0;
  logic [1:0]     owner;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]    wr_count;
  logic [15:0]    stall_count;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .data_in      (data_in),
    .grant        (grant),
    .write        (write),
    .dato_entrada (dato_entrada),
    .use_dw       (use_dw),
    .lleno        (lleno),
    .owner        (owner)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_count     (wr_count),
    .stall_count  (stall_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Model state: owner, words granted in the current burst (0 = no burst),
  // the in-flight write, and the FIFO contents.
  int         m_owner = 0;
  int         m_run = 0;
  bit         m_wq = 1'b0;
  logic [7:0] m_dq = '0;
  logic [7:0] fifo_q [$];
  int         m_writes = 0;
  int         m_stalls = 0;

  logic [N-1:0] req_v = '0;
  logic [7:0]   pdata [N];
  int           last_g = -1;
  logic [N-1:0] g_obs;
  int           gcount = 0;
  logic [N-1:0] one = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_space();
    return (fifo_q.size() + int'(m_wq)) < D;
  endfunction

  function automatic int model_winner(input logic [N-1:0] r);
    if (r == '0 || !model_space()) return -1;
    if (m_run > 0 && r[m_owner] && m_run < MB) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (r[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input bit rd);
    int g;
    bit sp;
    bit cont;
    @(negedge clk);
    req = req_v;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = pdata[i];
    #1;
    sp   = model_space();
    cont = (m_run > 0) && req_v[m_owner] && (m_run < MB);
    g    = model_winner(req_v);
    g_obs = grant;
    check("grant", grant, (g < 0) ? '0 : (one << g));
    if (req_v != '0 && !sp) m_stalls++;
    @(posedge clk);
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (m_wq) begin
      fifo_q.push_back(m_dq);
      m_writes++;
    end
    if (g >= 0) begin
      if (cont) m_run++;
      else begin
        m_owner = g;
        m_run   = 1;
      end
      m_dq = pdata[g];
    end else if (sp) begin
      m_run = 0;
    end
    m_wq   = (g >= 0);
    last_g = g;
    if (g >= 0) gcount++;
    #1;
    use_dw = 5'(fifo_q.size());
    lleno  = (fifo_q.size() == D);
    check("write", write, m_wq);
    check("dato", dato_entrada, m_dq);
    check("owner", owner, m_owner);
    if (g >= 0) $display("[TB] t=%0t grant=%b owner=%0d data=%h fifo=%0d", $time, g_obs, m_owner, m_dq, fifo_q.size());
  endtask

  task automatic advance(input int pct, input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (last_g == i) begin
        pdata[i] = 8'($urandom);
        req_v[i] = mask[i] && ($urandom_range(99) < pct);
      end else if (!req_v[i]) begin
        req_v[i] = mask[i] && ($urandom_range(99) < pct);
      end
    end
  endtask

  task automatic drain();
    req_v = '0;
    for (int i = 0; i < 80 && (fifo_q.size() > 0 || m_wq); i++) cycle(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_grant", grant, '0);
    check("rst_write", write, 1'b0);
    check("rst_dato", dato_entrada, 8'h00);
    check("rst_owner", owner, 2'd0);
    @(posedge clk);
    #1;
    check("rst_hold_grant", grant, '0);
    check("rst_hold_write", write, 1'b0);
    req = '0;
    @(negedge clk);
    reset    = 1'b1;
    m_owner  = 0;
    m_run    = 0;
    m_wq     = 1'b0;
    m_dq     = '0;
    m_writes = 0;
    m_stalls = 0;
    last_g   = -1;
  endtask

  initial begin
    int start;
    for (int i = 0; i < N; i++) pdata[i] = 8'($urandom);
    #1;
    check("init_grant", grant, '0);
    check("init_write", write, 1'b0);
    check("init_dato", dato_entrada, 8'h00);
    check("init_owner", owner, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single producer streams A0, A1, ...
    req_v = 4'b0001;
    pdata[0] = 8'hA0;
    for (int n = 0; n < 8; n++) begin
      cycle(1'b1);
      check("t1_grant", g_obs, 4'b0001);
      check("t1_data", dato_entrada, 8'hA0 + 8'(n));
      pdata[0] = pdata[0] + 8'h01;
    end

    // Owner 2 drops mid-burst; producer 3 takes over in the same cycle.
    req_v = 4'b0100;
    cycle(1'b1);
    cycle(1'b1);
    check("t4_own2", g_obs, 4'b0100);
    req_v = 4'b1000;
    cycle(1'b1);
    check("t4_grant3", g_obs, 4'b1000);
    check("t4_owner3", owner, 2'd3);
    req_v = '0;
    cycle(1'b1);

    // All requesting: bursts of MB words, rotating.
    req_v = 4'b1111;
    start = (m_owner + 1) % N;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1);
      check("t2_seq", g_obs, one << ((start + k / MB) % N));
    end

    // Fill the FIFO with no reads: exactly DEPTH grants, then stall.
    drain();
    req_v  = 4'b0001;
    gcount = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0);
      advance(100, 4'b0001);
    end
    check("t3_grants", gcount, D);
    check("t3_full_grant", g_obs, '0);
    check("t3_full_write", write, 1'b0);
    cycle(1'b1);
    check("t3_read_cycle", g_obs, '0);
    cycle(1'b0);
    check("t3_resume", g_obs, 4'b0001);

    drain();
    for (int k = 0; k < 300; k++) begin
      advance(60, 4'b1111);
      cycle(1'($urandom_range(1)));
    end

    // Reset in the middle of a burst with a write in flight.
    drain();
    req_v = 4'b1111;
    cycle(1'b1);
    cycle(1'b1);
    check("t5_pre_write", write, 1'b1);
    do_reset();
    req_v = 4'b0010;
    cycle(1'b1);
    check("t5_grant1", g_obs, 4'b0010);

    for (int k = 0; k < 150; k++) begin
      advance(70, 4'b1111);
      cycle(1'($urandom_range(1)));
    end
`ifdef FIFO_ARB_STATS_EN
    check("wr_count", wr_count, m_writes);
    check("stall_count", stall_count, m_stalls);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
